pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous reset, active-high (1 = reset) despite the suffix.
REQ-004 stall_req  input  1  load-to-use stall request from hazard detection, single-cycle meaning.
REQ-005 br_stall_req  input  1  load-feeding-BR request; requires a 2-cycle freeze.
REQ-006 br_taken  input  1  branch resolved taken in ID this cycle.
REQ-007 halt_in  input  1  HLT opcode (4'hF) present in ID.
REQ-008 imem_miss, dmem_miss  input  1 each  instruction/data memory not ready this cycle.
REQ-009 mem_ready  input  1  outstanding memory access completes this cycle.
REQ-010 pc_we, ifid_we, exmem_we  output  1 each  stage register write enables.
REQ-011 ifid_flush, idex_bubble, memwb_bubble  output  1 each  insert NOP into the named register.
REQ-012 halted  output  1  core stopped.
REQ-013 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-014 States SHALL be RUN, DWAIT, IWAIT, HALT; reset state RUN.
REQ-015 In RUN, with no request, all enables SHALL be 1 and all flush/bubble outputs 0.
REQ-016 Priority, highest first: dmem_miss, imem_miss, br_stall_req/stall_req, br_taken, halt_in.
REQ-017 RUN & dmem_miss -> DWAIT next cycle; in the same cycle pc_we=ifid_we=exmem_we=0, memwb_bubble=1.
REQ-018 DWAIT: outputs as REQ-017; returns to RUN on the cycle after mem_ready=1.
REQ-019 RUN & imem_miss (no dmem_miss) -> IWAIT; pc_we=0, ifid_flush=1, downstream enables 1.
REQ-020 IWAIT: outputs as REQ-019; dmem_miss in IWAIT SHALL move to DWAIT; mem_ready returns to RUN.
REQ-021 stall_req in RUN: pc_we=0, ifid_we=0, idex_bubble=1 for exactly that cycle; no state change.
REQ-022 br_stall_req in RUN: REQ-021 outputs this cycle and the next, tracked by one internal flag; the flag SHALL be cleared on DWAIT/IWAIT entry and re-requested by the hazard unit.
REQ-023 br_taken with no stall: ifid_flush=1, pc_we=1; br_taken during any stall SHALL be ignored (re-evaluated next cycle).
REQ-024 halt_in with no higher request: -> HALT; in HALT pc_we=0, ifid_flush=1, halted=1, downstream enables 1 to drain; exit only by reset.
REQ-025 stall_cnt SHALL increment every cycle pc_we=0 outside HALT, saturating at 16'hFFFF.
REQ-026 All outputs except stall_cnt are combinational from state + inputs; no added latency.

Reset
REQ-027 On rst_n=1, state=RUN, br flag=0, stall_cnt=0 immediately, independent of clk.
REQ-028 During reset, outputs SHALL equal RUN-idle values: enables 1, flush/bubble 0, halted 0.
REQ-029 Reset asserted mid-DWAIT/IWAIT/HALT SHALL abandon the wait; no memory handshake is retained.

Structure
REQ-030 State encoding (2-bit) and the HLT opcode constant SHALL live in the shared CPU package.
REQ-031 State and flag registers SHALL use the existing dff cell; stall_cnt SHALL be a sub-module sat_counter16.

Verification
REQ-032 stall_req=1 one cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle only; stall_cnt 0->1.
REQ-033 br_stall_req=1 one cycle -> freeze for 2 cycles, then RUN-idle; stall_cnt=2.
REQ-034 dmem_miss at t0, mem_ready at t3 -> memwb_bubble=1 t0..t3, RUN at t4; stall_cnt=4.
REQ-035 imem_miss and br_taken same cycle -> IWAIT, ifid_flush=1, pc_we=0; br_taken ignored.
REQ-036 halt_in -> halted=1 next cycle and held; async reset mid-HALT -> halted=0, stall_cnt=0 without clk edge.
REQ-037 Force 65536 stall cycles -> stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller: state encoding,
// HLT opcode and counter width.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 16;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/dff.sv
// Generic D flip-flop cell with asynchronous active-high reset to a
// parameterised value.
module dff #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: arbitrates memory misses, hazard stalls,
// taken branches and halt into stage-register enables and bubble inserts.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_req,
  input  logic        br_stall_req,
  input  logic        br_taken,
  input  logic        halt_in,
  input  logic        imem_miss,
  input  logic        dmem_miss,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  // rst_n is active-high: 1 holds the block in reset.
  logic               rst;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  state_t             state;
  state_t             next_state;
  logic               br_flag;
  logic               br_flag_d;
  logic               cnt_inc;

  assign rst     = rst_n;
  assign state   = state_t'(state_q);
  assign state_d = STATE_W'(next_state);

  dff #(.W(STATE_W), .RST_VAL(STATE_W'(RUN))) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  // Second freeze cycle owed to a load feeding a branch.
  dff #(.W(1), .RST_VAL(1'b0)) u_br_flag (
    .clk (clk),
    .rst (rst),
    .d   (br_flag_d),
    .q   (br_flag)
  );

  always_comb begin
    next_state   = state;
    br_flag_d    = 1'b0;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          if (dmem_miss) begin
            next_state   = DWAIT;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
          end else if (imem_miss) begin
            next_state = IWAIT;
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
          end else if (stall_req || br_stall_req || br_flag) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            br_flag_d   = br_stall_req;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
          end else if (halt_in) begin
            next_state = HALT;
          end
        end
        DWAIT: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          if (mem_ready) next_state = RUN;
        end
        IWAIT: begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          if (dmem_miss)      next_state = DWAIT;
          else if (mem_ready) next_state = RUN;
        end
        HALT: begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          halted     = 1'b1;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Frozen-PC cycles are counted everywhere except the terminal halt.
  assign cnt_inc = !pc_we && (state != HALT);

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, reset/saturation
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req, br_stall_req, br_taken, halt_in;
  logic        imem_miss, dmem_miss, mem_ready;
  logic        pc_we, ifid_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble, halted;
  logic [15:0] stall_cnt;
  logic [6:0]  act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_req    (stall_req),
    .br_stall_req (br_stall_req),
    .br_taken     (br_taken),
    .halt_in      (halt_in),
    .imem_miss    (imem_miss),
    .dmem_miss    (dmem_miss),
    .mem_ready    (mem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .exmem_we     (exmem_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  assign act = {pc_we, ifid_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble, halted};

  typedef struct packed {
    logic stall, br_stall, br_taken, halt, imiss, dmiss, mready;
  } in_t;

  typedef struct packed {
    logic pc_we, ifid_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble, halted;
  } out_t;

  typedef struct {
    in_t         stim;
    out_t        exp;
    logic [15:0] cnt;
  } vec_t;

  localparam out_t O_IDLE  = out_t'(7'b1110000);
  localparam out_t O_STALL = out_t'(7'b0010100);
  localparam out_t O_DFRZ  = out_t'(7'b0000010);
  localparam out_t O_IFL   = out_t'(7'b0111000);
  localparam out_t O_BRT   = out_t'(7'b1111000);
  localparam out_t O_HLT   = out_t'(7'b0111001);

  // input bit order: stall, br_stall, br_taken, halt, imiss, dmiss, mready
  localparam in_t I_NONE = in_t'(7'b0000000);
  localparam in_t I_STL  = in_t'(7'b1000000);
  localparam in_t I_BRS  = in_t'(7'b0100000);
  localparam in_t I_BRT  = in_t'(7'b0010000);
  localparam in_t I_HLT  = in_t'(7'b0001000);
  localparam in_t I_IM   = in_t'(7'b0000100);
  localparam in_t I_DM   = in_t'(7'b0000010);
  localparam in_t I_RDY  = in_t'(7'b0000001);

  vec_t vecs[34];

  // behavioural model: mode 0 run, 1 data wait, 2 instr wait, 3 halted
  int m_mode;
  bit m_extra;
  int m_cnt;

  task automatic chk(input string nm, input int idx, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s #%0d actual=%h required=%h", nm, idx, a, e);
    end
  endtask

  task automatic drive(input in_t v);
    {stall_req, br_stall_req, br_taken, halt_in, imem_miss, dmem_miss, mem_ready} = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(I_NONE);
    #1;
    chk("rst_ctrl", 0, 16'(act), 16'(O_IDLE));
    chk("rst_cnt", 0, stall_cnt, 16'h0000);
    @(negedge clk);
    rst_n   = 1'b0;
    m_mode  = 0;
    m_extra = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input in_t v, output out_t e);
    int prev_mode;
    bit frozen_br;
    prev_mode = m_mode;
    frozen_br = m_extra;
    m_extra   = 1'b0;
    e         = O_IDLE;
    if (m_mode == 3) begin
      e = O_HLT;
    end else if (m_mode == 1) begin
      e = O_DFRZ;
      if (v.mready) m_mode = 0;
    end else if (m_mode == 2) begin
      e = O_IFL;
      m_mode = v.dmiss ? 1 : (v.mready ? 0 : 2);
    end else if (v.dmiss) begin
      e = O_DFRZ;
      m_mode = 1;
    end else if (v.imiss) begin
      e = O_IFL;
      m_mode = 2;
    end else if (v.stall || v.br_stall || frozen_br) begin
      e = O_STALL;
      m_extra = v.br_stall;
    end else if (v.br_taken) begin
      e = O_BRT;
    end else if (v.halt) begin
      m_mode = 3;
    end
    if (!e.pc_we && prev_mode != 3) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
  endtask

  initial begin
    vecs[0]  = '{I_NONE,             O_IDLE,  16'd0};
    vecs[1]  = '{I_STL,              O_STALL, 16'd0};
    vecs[2]  = '{I_NONE,             O_IDLE,  16'd1};
    vecs[3]  = '{I_BRS,              O_STALL, 16'd1};
    vecs[4]  = '{I_NONE,             O_STALL, 16'd2};
    vecs[5]  = '{I_NONE,             O_IDLE,  16'd3};
    vecs[6]  = '{I_BRT,              O_BRT,   16'd3};
    vecs[7]  = '{I_STL | I_BRT,      O_STALL, 16'd3};
    vecs[8]  = '{I_DM,               O_DFRZ,  16'd4};
    vecs[9]  = '{I_NONE,             O_DFRZ,  16'd5};
    vecs[10] = '{I_NONE,             O_DFRZ,  16'd6};
    vecs[11] = '{I_RDY,              O_DFRZ,  16'd7};
    vecs[12] = '{I_NONE,             O_IDLE,  16'd8};
    vecs[13] = '{I_IM | I_BRT,       O_IFL,   16'd8};
    vecs[14] = '{I_NONE,             O_IFL,   16'd9};
    vecs[15] = '{I_DM,               O_IFL,   16'd10};
    vecs[16] = '{I_NONE,             O_DFRZ,  16'd11};
    vecs[17] = '{I_RDY,              O_DFRZ,  16'd12};
    vecs[18] = '{I_NONE,             O_IDLE,  16'd13};
    vecs[19] = '{I_IM,               O_IFL,   16'd13};
    vecs[20] = '{I_RDY,              O_IFL,   16'd14};
    vecs[21] = '{I_NONE,             O_IDLE,  16'd15};
    vecs[22] = '{I_BRS,              O_STALL, 16'd15};
    vecs[23] = '{I_DM,               O_DFRZ,  16'd16};
    vecs[24] = '{I_RDY,              O_DFRZ,  16'd17};
    vecs[25] = '{I_NONE,             O_IDLE,  16'd18};
    vecs[26] = '{I_DM | I_IM | I_STL, O_DFRZ, 16'd18};
    vecs[27] = '{I_RDY,              O_DFRZ,  16'd19};
    vecs[28] = '{I_BRS | I_BRT | I_HLT, O_STALL, 16'd20};
    vecs[29] = '{I_HLT,              O_STALL, 16'd21};
    vecs[30] = '{I_HLT,              O_IDLE,  16'd22};
    vecs[31] = '{I_STL,              O_HLT,   16'd22};
    vecs[32] = '{I_DM,               O_HLT,   16'd22};
    vecs[33] = '{I_NONE,             O_HLT,   16'd22};

    rst_n = 1'b1;
    drive(I_NONE);
    #2;
    chk("reset_ctrl", 0, 16'(act), 16'(O_IDLE));
    chk("reset_cnt", 0, stall_cnt, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;

    // directed vector table
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      drive(vecs[i].stim);
      #1;
      chk("tbl_ctrl", i, 16'(act), 16'(vecs[i].exp));
      chk("tbl_cnt", i, stall_cnt, vecs[i].cnt);
    end

    // asynchronous reset while halted, with a stall request pending
    @(negedge clk);
    drive(I_STL);
    #1;
    chk("halt_held", 0, 16'(halted), 16'd1);
    #1 rst_n = 1'b1;
    #1;
    chk("async_halted", 0, 16'(halted), 16'd0);
    chk("async_cnt", 0, stall_cnt, 16'h0000);
    chk("async_ctrl", 0, 16'(act), 16'(O_IDLE));
    @(negedge clk);
    rst_n = 1'b0;
    drive(I_NONE);

    // reset in the middle of a data wait abandons it
    @(negedge clk);
    drive(I_DM);
    @(negedge clk);
    drive(I_NONE);
    #1;
    chk("dwait_ctrl", 0, 16'(act), 16'(O_DFRZ));
    #1 rst_n = 1'b1;
    #1;
    chk("dwait_rst_ctrl", 0, 16'(act), 16'(O_IDLE));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("dwait_abandon", 0, 16'(act), 16'(O_IDLE));
    chk("dwait_abandon_cnt", 0, stall_cnt, 16'h0000);

    // saturation: hold a stall long enough to exceed the counter range
    for (int n = 0; n < 65540; n++) begin
      @(negedge clk);
      drive(I_STL);
      #1;
      if (n == 65534 || n == 65535 || n == 65539)
        chk("sat_cnt", n, stall_cnt, (n >= 65535) ? 16'hFFFF : 16'(n));
    end
    drive(I_NONE);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in_t  v;
      out_t e;
      int   exp_cnt;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        v.stall    = ($urandom_range(0, 5) == 0);
        v.br_stall = ($urandom_range(0, 7) == 0);
        v.br_taken = ($urandom_range(0, 3) == 0);
        v.halt     = ($urandom_range(0, 31) == 0);
        v.imiss    = ($urandom_range(0, 7) == 0);
        v.dmiss    = ($urandom_range(0, 9) == 0);
        v.mready   = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        drive(v);
        #1;
        exp_cnt = m_cnt;
        model_step(v, e);
        chk("rnd_ctrl", k, 16'(act), 16'(e));
        chk("rnd_cnt", k, stall_cnt, 16'(exp_cnt));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
